// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO of arbitrary depth with show-ahead read,
// registered flags, fill count, sticky error flags and synchronous flush.
module fifo_sync_param #(
    parameter int DWIDTH    = 4,
    parameter int DEPTH     = 13,
    parameter int AF_THRESH = 11,
    parameter int AE_THRESH = 2,
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wen,
    input  logic [DWIDTH-1:0] din,
    output logic              full,
    output logic              almost_full,
    input  logic              ren,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    if (DWIDTH < 1) begin : g_bad_dwidth
        $error("fifo_sync_param: DWIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_unf;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_err;
    logic              w_rd_err;
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [CW-1:0]     w_count_nxt;

    // Accepts use the registered flags, so a write while full is dropped
    // even when a read frees a slot in the same cycle.
    assign w_wr_acc = wen & ~r_full;
    assign w_rd_acc = ren & ~r_empty;
    assign w_wr_err = wen & r_full & ~flush;
    assign w_rd_err = ren & r_empty & ~flush;

    // Non power-of-two depth: wrap by explicit compare.
    assign w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0
                                                      : r_wr_ptr + AW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0
                                                      : r_rd_ptr + AW'(1);

    assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= CW'(AF_THRESH));
            r_ae    <= (w_count_nxt <= CW'(AE_THRESH));
        end
    end

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_wr_err | (r_ovf & ~err_clr);
            r_unf <= w_rd_err | (r_unf & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout         = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: randomized and directed checks of fifo_sync_param
// at DEPTH 13, 2 and 24 against a queue-based reference model.
module tb_fifo_sync_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, wen, ren, err_clr;
    logic [7:0] din;

    logic [3:0] dout0, dout1;
    logic [7:0] dout2;
    logic [3:0] cnt0;
    logic [1:0] cnt1;
    logic [4:0] cnt2;
    logic f0, e0, af0, ae0, ov0, un0;
    logic f1, e1, af1, ae1, ov1, un1;
    logic f2, e2, af2, ae2, ov2, un2;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_sync_param #(.DWIDTH(4), .DEPTH(13), .AF_THRESH(11), .AE_THRESH(2)) u_d13 (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .din(din[3:0]),
        .full(f0), .almost_full(af0), .ren(ren), .dout(dout0), .empty(e0),
        .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0),
        .err_clr(err_clr));

    fifo_sync_param #(.DWIDTH(4), .DEPTH(2), .AF_THRESH(2), .AE_THRESH(0)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .din(din[3:0]),
        .full(f1), .almost_full(af1), .ren(ren), .dout(dout1), .empty(e1),
        .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1),
        .err_clr(err_clr));

    fifo_sync_param #(.DWIDTH(8), .DEPTH(24), .AF_THRESH(20), .AE_THRESH(3)) u_d24 (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .din(din),
        .full(f2), .almost_full(af2), .ren(ren), .dout(dout2), .empty(e2),
        .almost_empty(ae2), .count(cnt2), .overflow(ov2), .underflow(un2),
        .err_clr(err_clr));

    // Flags packed as {full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [5:0] get_flags(int k);
        case (k)
            0:       return {f0, e0, af0, ae0, ov0, un0};
            1:       return {f1, e1, af1, ae1, ov1, un1};
            default: return {f2, e2, af2, ae2, ov2, un2};
        endcase
    endfunction

    function automatic int get_count(int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int get_dout(int k);
        case (k)
            0:       return int'(dout0);
            1:       return int'(dout1);
            default: return int'(dout2);
        endcase
    endfunction

    function automatic logic [5:0] exp_flags(int n, int depth, int af, int ae,
                                             bit ov, bit un);
        return {n == depth, n == 0, n >= af, n <= ae, ov, un};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; wen = 0; ren = 0; err_clr = 0; din = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (get_count(k) !== 0) begin
                n_bad++;
                $display("FAIL reset_count[%0d]: got %0d want 0", k, get_count(k));
            end
            n_cmp++;
            if (get_flags(k) !== 6'b010100) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: got %b want 010100", k, get_flags(k));
            end
        end
    endtask

    task automatic test_fill_drain(int k, int depth, int af, int ae);
        logic [5:0] ef;
        do_reset();
        for (int i = 0; i < depth; i++) begin
            wen = 1; din = 8'(i);
            tick();
            ef = exp_flags(i + 1, depth, af, ae, 0, 0);
            n_cmp++;
            if (get_count(k) !== i + 1 || get_flags(k) !== ef) begin
                n_bad++;
                $display("FAIL fill[%0d] n=%0d: count %0d flags %b want %0d %b",
                         k, i + 1, get_count(k), get_flags(k), i + 1, ef);
            end
        end
        din = 8'd15;
        tick();
        wen = 0;
        ef = exp_flags(depth, depth, af, ae, 1, 0);
        n_cmp++;
        if (get_count(k) !== depth || get_flags(k) !== ef) begin
            n_bad++;
            $display("FAIL overflow[%0d]: count %0d flags %b want %0d %b",
                     k, get_count(k), get_flags(k), depth, ef);
        end
        err_clr = 1;
        tick();
        err_clr = 0;
        for (int i = 0; i < depth; i++) begin
            n_cmp++;
            if (get_dout(k) !== i) begin
                n_bad++;
                $display("FAIL drain_dout[%0d] i=%0d: got %0d want %0d",
                         k, i, get_dout(k), i);
            end
            ren = 1;
            tick();
            ren = 0;
        end
        ren = 1;
        tick();
        ren = 0;
        ef = exp_flags(0, depth, af, ae, 0, 1);
        n_cmp++;
        if (get_count(k) !== 0 || get_flags(k) !== ef) begin
            n_bad++;
            $display("FAIL underflow[%0d]: count %0d flags %b want 0 %b",
                     k, get_count(k), get_flags(k), ef);
        end
        err_clr = 1;
        tick();
        err_clr = 0;
        ef = exp_flags(0, depth, af, ae, 0, 0);
        n_cmp++;
        if (get_flags(k) !== ef) begin
            n_bad++;
            $display("FAIL err_clr[%0d]: flags %b want %b", k, get_flags(k), ef);
        end
    endtask

    task automatic test_random_wrap();
        logic [3:0] q[$];
        bit ov = 0, un = 0, fl, em;
        int pw;
        int n_wr = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pw      = ((c / 40) % 2 == 0) ? 70 : 30;
            wen     = ($urandom_range(0, 99) < pw);
            ren     = ($urandom_range(0, 99) < 100 - pw);
            err_clr = ($urandom_range(0, 99) < 5);
            din     = 8'($urandom);
            fl = (q.size() == 13);
            em = (q.size() == 0);
            if (!em) begin
                n_cmp++;
                if (dout0 !== q[0]) begin
                    n_bad++;
                    $display("FAIL rand_dout c=%0d: got %h want %h", c, dout0, q[0]);
                end
            end
            ov = (wen && fl) || (ov && !err_clr);
            un = (ren && em) || (un && !err_clr);
            if (ren && !em) void'(q.pop_front());
            if (wen && !fl) begin
                q.push_back(din[3:0]);
                n_wr++;
            end
            tick();
            n_cmp++;
            if (cnt0 !== q.size() ||
                get_flags(0) !== exp_flags(q.size(), 13, 11, 2, ov, un)) begin
                n_bad++;
                $display("FAIL rand_state c=%0d: count %0d flags %b want %0d %b",
                         c, cnt0, get_flags(0), q.size(),
                         exp_flags(q.size(), 13, 11, 2, ov, un));
            end
        end
        idle();
        n_cmp++;
        if (n_wr < 40) begin
            n_bad++;
            $display("FAIL rand_coverage: writes %0d want >= 40", n_wr);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            wen = 1; din = 8'(i + 1);
            tick();
        end
        wen = 1; ren = 1; din = 8'd9;
        tick();
        idle();
        n_cmp++;
        if (cnt0 !== 12 || get_flags(0) !== 6'b001010) begin
            n_bad++;
            $display("FAIL full_rw: count %0d flags %b want 12 001010", cnt0, get_flags(0));
        end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (dout0 !== 4'(i + 2)) begin
                n_bad++;
                $display("FAIL full_rw_dout i=%0d: got %0d want %0d", i, dout0, i + 2);
            end
            ren = 1;
            tick();
            ren = 0;
        end
    endtask

    task automatic test_count1_and_flush();
        do_reset();
        wen = 1; din = 8'd5;
        tick();
        wen = 1; ren = 1; din = 8'd10;
        tick();
        idle();
        n_cmp++;
        if (cnt0 !== 1 || dout0 !== 4'd10 || get_flags(0) !== 6'b000100) begin
            n_bad++;
            $display("FAIL count1: count %0d dout %0d flags %b want 1 10 000100",
                     cnt0, dout0, get_flags(0));
        end
        do_reset();
        for (int i = 0; i < 14; i++) begin
            wen = 1; din = 8'(i);
            tick();
        end
        wen = 0;
        for (int i = 0; i < 6; i++) begin
            ren = 1;
            tick();
        end
        ren = 0;
        n_cmp++;
        if (cnt0 !== 7) begin
            n_bad++;
            $display("FAIL flush_pre: count %0d want 7", cnt0);
        end
        flush = 1; wen = 1; din = 8'd3;
        tick();
        wen = 0; ren = 1;
        n_cmp++;
        if (cnt0 !== 0 || get_flags(0) !== 6'b010110) begin
            n_bad++;
            $display("FAIL flush: count %0d flags %b want 0 010110", cnt0, get_flags(0));
        end
        tick();
        n_cmp++;
        if (cnt0 !== 0 || get_flags(0) !== 6'b010110) begin
            n_bad++;
            $display("FAIL flush_ren: count %0d flags %b want 0 010110", cnt0, get_flags(0));
        end
        idle();
        wen = 1; din = 8'd6;
        tick();
        idle();
        n_cmp++;
        if (cnt0 !== 1 || dout0 !== 4'd6) begin
            n_bad++;
            $display("FAIL post_flush: count %0d dout %0d want 1 6", cnt0, dout0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ren = 1;
        tick();
        ren = 0;
        n_cmp++;
        if (un0 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_unf: got %b want 1", un0);
        end
        for (int i = 0; i < 5; i++) begin
            wen = 1; din = 8'(i);
            tick();
        end
        n_cmp++;
        if (cnt0 !== 5) begin
            n_bad++;
            $display("FAIL mid_count: got %0d want 5", cnt0);
        end
        rst = 1; wen = 1; ren = 1;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (get_count(k) !== 0 || get_flags(k) !== 6'b010100) begin
                n_bad++;
                $display("FAIL mid_reset[%0d]: count %0d flags %b want 0 010100",
                         k, get_count(k), get_flags(k));
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_drain(0, 13, 11, 2);
        test_random_wrap();
        test_full_rw();
        test_count1_and_flush();
        test_reset_mid();
        test_fill_drain(1, 2, 2, 0);
        test_fill_drain(2, 24, 20, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
